uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Serial UART receiver with an 8-bit receive FIFO, the receive-side counterpart to the SOC's transmit emitter. It samples the `RXD` pin, deframes 8N1 characters and queues them for the processor. The SOC decodes an IO-page word address and drives the pop and clear strobes below. `rx_data` and the status bits are returned on the IO read path.

## Interface
- `clk_freq_hz`, default 10000000: system clock frequency.
- `baud_rate`, default 1000000: line rate. `C = clk_freq_hz/baud_rate` (integer, ≥ 4), `H = C/2` (floor).
- `depth`, default 8: FIFO entries; power of two, ≥ 2.
- `clk`  in  1: system clock. All state changes on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `rxd`  in  1: asynchronous serial input; idle high.
- `rx_pop`  in  1: single-cycle strobe (IO read of the data word); removes the head entry.
- `clr_err`  in  1: clears the sticky error flags.
- `rx_data`  out  8: head entry, first-word-fall-through; reads 0 when empty.
- `rx_valid`  out  1: FIFO not empty.
- `rx_full`  out  1: FIFO holds `depth` entries.
- `rx_count`  out  $clog2(depth)+1: number of entries held.
- `overrun`  out  1: sticky; a received byte was dropped because the FIFO was full.
- `frame_err`  out  1: sticky; a stop bit sampled low.

## Operation
- **Input sync:** `rxd` passes through a 2-FF synchronizer, preset to 1 on reset. `rxs` is the synchronizer output.
- **Receiver FSM states:** IDLE, START, DATA, STOP. One bit-timer counter and one 3-bit bit index.
  - IDLE: on `rxs`==0, go to START and load the timer for `H` cycles.
  - START: at timer expiry, sample `rxs`. If 1 (glitch), return to IDLE with nothing recorded. If 0, go to DATA, set bit index 0, load the timer for `C`.
  - DATA: at each expiry, shift `rxs` in LSB-first and reload `C`. After bit 7, go to STOP with timer `C`.
  - STOP: at expiry, sample `rxs`. If 1, push the byte. If 0, set `frame_err` and discard the byte. Return to IDLE in both cases. No wait for the line to go high; IDLE requires a low level to start.
- **FIFO:** `depth` × 8 array with read/write pointers of `$clog2(depth)+1` bits. Pointers wrap modulo 2·`depth`. Empty when pointers are equal; full when they differ only in the MSB.
  - Pop is effective only when `rx_pop` && `rx_valid`. Pop on an empty FIFO is ignored with no flag.
  - Push when full and no pop in the same cycle: the byte is dropped and `overrun` is set.
  - Push and pop in the same cycle: both take effect, count unchanged. When full, this push is accepted with no overrun.
- **Error flags:** both flags are sticky until `clr_err`. If a set and `clr_err` occur in the same cycle, the set wins.
- **Reset mid-frame:** the FSM returns to IDLE, the partial byte is lost, the FIFO is emptied, and the flags are cleared. The receiver resynchronizes on the next low level after reset deasserts.
- `rx_count` is exact and 0..`depth`.

## Timing
- **Reset values:** `rx_data`=0, `rx_valid`=0, `rx_full`=0, `rx_count`=0, `overrun`=0, `frame_err`=0. The FSM is in IDLE and both synchronizer flops are 1.
- `rxs` lags `rxd` by 2 cycles.
- Let cycle 0 be the first cycle IDLE sees `rxs`==0. Sample points:
  - start check at cycle `H`;
  - data bit i at cycle `H+(i+1)·C`;
  - stop at cycle `H+9·C`.
- The push is registered on the stop-sample edge. `rx_valid`, `rx_data` and `rx_count` update the following cycle, at `H+9·C+1` (cycle 96 with the defaults).
- **Pop:** `rx_data` shows the next entry, or 0, and `rx_count` decrements, in the cycle after the `rx_pop` edge. A processor load that samples `rx_data` in the strobe cycle therefore gets the popped value.
- `overrun` and `frame_err` assert in the cycle after the offending sample and deassert in the cycle after `clr_err`.
- Back-to-back frames are received with 1 stop bit and no idle gap.

## Test plan
- Defaults. Send 0x41 at 1 Mbaud (10 clk/bit) → `rx_valid` rises at cycle 96 after `rxs` falls, `rx_data`=0x41, `rx_count`=1. Pop → `rx_valid`=0, `rx_data`=0.
- 3-cycle low glitch on idle `rxd` → no push, flags stay 0, FSM back in IDLE. A following real frame 0x5A is received correctly.
- Send 9 bytes 0x00..0x08 without popping → `rx_full`=1, `rx_count`=8, `overrun`=1. Popping 8 times yields 0x00..0x07; 0x08 is lost. `clr_err` → `overrun`=0.
- Frame 0x33 with stop bit held low → `frame_err`=1, `rx_count` unchanged. The next clean frame 0xC3 is queued. `clr_err` in the same cycle as a new framing error → `frame_err` stays 1.
- FIFO full, with `rx_pop` asserted in the exact stop-sample cycle of a 9th byte 0xEE → head popped, 0xEE accepted, `rx_count` stays 8, `overrun`=0. Wrap-around order is checked over 20 bytes.
- Assert `reset` mid-DATA with 3 bytes queued → after reset all outputs are at their reset values. A subsequent byte 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a first-word-fall-through receive FIFO
module uart_rx_fifo #(
  parameter int clk_freq_hz = 10000000,
  parameter int baud_rate   = 1000000,
  parameter int depth       = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_rxd,
  input  logic                   i_rx_pop,
  input  logic                   i_clr_err,
  output logic [7:0]             o_rx_data,
  output logic                   o_rx_valid,
  output logic                   o_rx_full,
  output logic [$clog2(depth):0] o_rx_count,
  output logic                   o_overrun,
  output logic                   o_frame_err
);

  // Clocks per bit, and the half-bit offset that centres every sample in its bit.
  localparam int C  = clk_freq_hz / baud_rate;
  localparam int H  = C / 2;
  localparam int TW = $clog2(C);
  localparam int AW = $clog2(depth);

  // Timer expires when it reaches zero, so load value N-1 gives N cycles.
  localparam logic [TW-1:0] C_LOAD = TW'(C - 1);
  localparam logic [TW-1:0] H_LOAD = TW'(H - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic          r_sync1;
  logic          r_sync2;
  logic          w_rxs;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic [2:0]    r_bit_idx;
  logic [2:0]    w_bit_idx_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          w_expired;
  logic          w_push;
  logic          w_frame_set;

  logic [7:0]    r_mem [depth];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr_en;
  logic          w_ovr_set;

  logic          r_overrun;
  logic          r_frame_err;

  // Two-flop synchronizer; preset high so reset looks like an idle line.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs     = r_sync2;
  assign w_expired = (r_timer == '0);

  // Receiver state, bit timer, bit index and shift register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // Deframing: start check at half a bit, then one sample per bit period.
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = w_expired ? r_timer : r_timer - TW'(1);
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_push        = 1'b0;
    w_frame_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_state_nxt = S_START;
          w_timer_nxt = H_LOAD;
        end
      end
      S_START: begin
        if (w_expired) begin
          if (w_rxs) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt   = S_DATA;
            w_bit_idx_nxt = 3'd0;
            w_timer_nxt   = C_LOAD;
          end
        end
      end
      S_DATA: begin
        if (w_expired) begin
          w_shift_nxt   = {w_rxs, r_shift[7:1]};
          w_timer_nxt   = C_LOAD;
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (w_expired) begin
          w_state_nxt = S_IDLE;
          if (w_rxs) begin
            w_push = 1'b1;
          end else begin
            w_frame_set = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One extra pointer bit separates full from empty when the indices match.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop     = i_rx_pop && !w_empty;
  assign w_wr_en   = w_push && (!w_full || w_pop);
  assign w_ovr_set = w_push && w_full && !w_pop;

  // Storage array; no reset needed because the empty flag masks stale entries.
  always_ff @(posedge i_clk) begin
    if (w_wr_en && !i_reset) begin
      r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
    end
  end

  // FIFO pointers; a pop frees the head slot in the same edge a full push lands.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Sticky error flags; a new error outranks a simultaneous clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (i_clr_err) begin
        r_overrun <= 1'b0;
      end
      if (w_frame_set) begin
        r_frame_err <= 1'b1;
      end else if (i_clr_err) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  assign o_rx_data   = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_rx_valid  = !w_empty;
  assign o_rx_full   = w_full;
  assign o_rx_count  = r_wr_ptr - r_rd_ptr;
  assign o_overrun   = r_overrun;
  assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo against a queue model
module tb_uart_rx_fifo;

  localparam int C     = 10;
  localparam int H     = 5;
  localparam int DEPTH = 8;
  // Edges from the driven start edge to the stop-sample edge: 2 sync + 1 detect + H + 9C.
  localparam int STOP_OFS = 3 + H + 9 * C;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_rxd;
  logic       i_rx_pop;
  logic       i_clr_err;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_rx_full;
  logic [3:0] o_rx_count;
  logic       o_overrun;
  logic       o_frame_err;

  uart_rx_fifo #(
    .clk_freq_hz(10000000),
    .baud_rate  (1000000),
    .depth      (DEPTH)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_rxd      (i_rxd),
    .i_rx_pop   (i_rx_pop),
    .i_clr_err  (i_clr_err),
    .o_rx_data  (o_rx_data),
    .o_rx_valid (o_rx_valid),
    .o_rx_full  (o_rx_full),
    .o_rx_count (o_rx_count),
    .o_overrun  (o_overrun),
    .o_frame_err(o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int         at;
    logic [7:0] data;
    logic       stop;
  } ev_t;

  ev_t        ev[$];
  logic [7:0] mq[$];
  logic       m_ovr  = 1'b0;
  logic       m_ferr = 1'b0;
  logic [7:0] strobe_data;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Model: frames land at their stop-sample edge; the queue and flags follow the FIFO rules.
  always @(posedge i_clk) begin
    logic       pop;
    logic       push;
    logic       set_o;
    logic       set_f;
    logic [7:0] pb;
    cyc++;
    if (i_reset) begin
      mq.delete();
      ev.delete();
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
    end else begin
      pop   = i_rx_pop && (mq.size() > 0);
      push  = 1'b0;
      set_o = 1'b0;
      set_f = 1'b0;
      pb    = 8'h00;
      for (int k = 0; k < ev.size(); k++) begin
        if (ev[k].at == cyc) begin
          if (ev[k].stop) begin
            if (mq.size() < DEPTH || pop) push = 1'b1;
            else set_o = 1'b1;
          end else begin
            set_f = 1'b1;
          end
          pb = ev[k].data;
          ev.delete(k);
          break;
        end
      end
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(pb);
      m_ovr  = set_o ? 1'b1 : (i_clr_err ? 1'b0 : m_ovr);
      m_ferr = set_f ? 1'b1 : (i_clr_err ? 1'b0 : m_ferr);
    end
  end

  // Compare every cycle, mid-period.
  always @(negedge i_clk) begin
    if (cyc > 0) begin
      check("m_valid", o_rx_valid, mq.size() != 0);
      check("m_data", o_rx_data, (mq.size() != 0) ? mq[0] : 8'h00);
      check("m_count", o_rx_count, mq.size());
      check("m_full", o_rx_full, mq.size() == DEPTH);
      check("m_overrun", o_overrun, m_ovr);
      check("m_frame_err", o_frame_err, m_ferr);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Entered and left at 1 time unit after an edge so frames can run back to back.
  // strobe: 0 none, 1 pop, 2 clr_err, asserted for the stop-sample edge.
  task automatic send_frame(input logic [7:0] d, input logic stopb, input int strobe);
    logic [9:0] frame;
    frame = {stopb, d, 1'b0};
    ev.push_back('{cyc + STOP_OFS, d, stopb});
    for (int b = 0; b < 10; b++) begin
      for (int j = 0; j < C; j++) begin
        i_rxd = frame[b];
        if (b == 9) begin
          i_rx_pop  = (strobe == 1) && (j == H + 2);
          i_clr_err = (strobe == 2) && (j == H + 2);
          if (strobe == 1 && j == H + 2) strobe_data = o_rx_data;
        end
        tick(1);
      end
    end
    i_rxd     = 1'b1;
    i_rx_pop  = 1'b0;
    i_clr_err = 1'b0;
  endtask

  task automatic pop_expect(input logic [7:0] exp, input string nm);
    i_rx_pop = 1'b1;
    check(nm, o_rx_data, exp);
    tick(1);
    i_rx_pop = 1'b0;
  endtask

  task automatic clr();
    i_clr_err = 1'b1;
    tick(1);
    i_clr_err = 1'b0;
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_data"}, o_rx_data, 8'h00);
    check({nm, "_valid"}, o_rx_valid, 1'b0);
    check({nm, "_full"}, o_rx_full, 1'b0);
    check({nm, "_count"}, o_rx_count, 4'd0);
    check({nm, "_ovr"}, o_overrun, 1'b0);
    check({nm, "_ferr"}, o_frame_err, 1'b0);
  endtask

  initial begin
    logic [7:0] sent[20];
    int         rd;
    i_reset   = 1'b1;
    i_rxd     = 1'b1;
    i_rx_pop  = 1'b0;
    i_clr_err = 1'b0;
    strobe_data = 8'h00;
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_vals("reset");
    i_reset = 1'b0;
    tick(2);

    // Single byte with exact arrival edge.
    fork
      send_frame(8'h41, 1'b1, 0);
      begin
        tick(STOP_OFS - 1);
        check("t1_valid_before", o_rx_valid, 1'b0);
        tick(1);
        check("t1_valid_at", o_rx_valid, 1'b1);
        check("t1_data", o_rx_data, 8'h41);
        check("t1_count", o_rx_count, 4'd1);
      end
    join
    pop_expect(8'h41, "t1_pop");
    check("t1_valid_after", o_rx_valid, 1'b0);
    check("t1_data_after", o_rx_data, 8'h00);

    // Short low glitch, then a real frame.
    i_rxd = 1'b0;
    tick(3);
    i_rxd = 1'b1;
    tick(30);
    check("t2_count", o_rx_count, 4'd0);
    check("t2_ferr", o_frame_err, 1'b0);
    send_frame(8'h5A, 1'b1, 0);
    check("t2_data", o_rx_data, 8'h5A);
    pop_expect(8'h5A, "t2_pop");

    // Nine bytes without popping: overrun.
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 0);
    check("t3_full", o_rx_full, 1'b1);
    check("t3_count", o_rx_count, 4'd8);
    check("t3_ovr", o_overrun, 1'b1);
    for (int i = 0; i < 8; i++) pop_expect(8'(i), "t3_pop");
    check("t3_empty", o_rx_valid, 1'b0);
    clr();
    check("t3_ovr_clr", o_overrun, 1'b0);

    // Framing errors and set-beats-clear.
    send_frame(8'h33, 1'b0, 0);
    tick(2 * C);
    check("t4_ferr", o_frame_err, 1'b1);
    check("t4_count", o_rx_count, 4'd0);
    send_frame(8'hC3, 1'b1, 0);
    check("t4_data", o_rx_data, 8'hC3);
    pop_expect(8'hC3, "t4_pop");
    clr();
    check("t4_ferr_clr", o_frame_err, 1'b0);
    send_frame(8'h99, 1'b0, 2);
    check("t4_ferr_set_wins", o_frame_err, 1'b1);
    tick(2 * C);
    clr();
    check("t4_ferr_clr2", o_frame_err, 1'b0);

    // Full FIFO with a pop on the stop-sample edge of a ninth byte.
    for (int i = 0; i < 8; i++) send_frame(8'hE0 + 8'(i), 1'b1, 0);
    send_frame(8'hEE, 1'b1, 1);
    check("t5_popped", strobe_data, 8'hE0);
    check("t5_count", o_rx_count, 4'd8);
    check("t5_full", o_rx_full, 1'b1);
    check("t5_ovr", o_overrun, 1'b0);
    for (int i = 1; i < 8; i++) pop_expect(8'hE0 + 8'(i), "t5_pop");
    pop_expect(8'hEE, "t5_pop_ee");

    // Wrap-around ordering over 20 bytes.
    rd = 0;
    for (int i = 0; i < 20; i++) begin
      sent[i] = 8'(i * 37 + 5);
      send_frame(sent[i], 1'b1, 0);
      if (i >= 3) begin
        pop_expect(sent[rd], "t5_wrap");
        rd++;
      end
    end
    while (rd < 20) begin
      pop_expect(sent[rd], "t5_wrap_drain");
      rd++;
    end
    check("t5_wrap_empty", o_rx_count, 4'd0);

    // Reset in the middle of a data bit with bytes queued.
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    send_frame(8'h33, 1'b1, 0);
    check("t6_count", o_rx_count, 4'd3);
    i_rxd = 1'b0;
    tick(C);
    i_rxd = 1'b1;
    tick(C);
    i_rxd = 1'b0;
    tick(C);
    i_rxd = 1'b1;
    tick(5);
    i_reset = 1'b1;
    tick(2);
    i_reset = 1'b0;
    check_reset_vals("t6_rst");
    tick(20);
    check("t6_idle_count", o_rx_count, 4'd0);
    send_frame(8'h7E, 1'b1, 0);
    check("t6_data", o_rx_data, 8'h7E);
    check("t6_count1", o_rx_count, 4'd1);
    pop_expect(8'h7E, "t6_pop");
    tick(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
